// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the multicycle control unit.
//   - datapath / instruction field widths
//   - opcode constants and ALU select codes
//   - FSM state encoding
//   - small decode helpers used by mips_ctrl
package mips_pkg;

  localparam int WORD_SIZE   = 16;
  localparam int OP_SIZE     = 4;
  localparam int OFFSET_SIZE = 4;
  localparam int MEM_SIZE    = 8;
  localparam int REG_ADDR    = 4;
  localparam int NUM_REGS    = 1 << REG_ADDR;

  // Opcodes 0x0-0x7 are register-register ALU operations whose opcode is the
  // ALU select itself; the rest are control / immediate forms.
  localparam logic [3:0] OP_LI   = 4'h8;
  localparam logic [3:0] OP_BEQ  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;
  localparam logic [3:0] ALU_SLL = 4'h5;
  localparam logic [3:0] ALU_SRL = 4'h6;
  localparam logic [3:0] ALU_SLT = 4'h7;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  function automatic logic is_alu_op(input logic [3:0] op);
    return ~op[3];
  endfunction

  // ALU select presented during EXEC. BEQ compares by subtraction; opcodes
  // that do not use the ALU get a harmless ADD.
  function automatic logic [3:0] alu_sel_for(input logic [3:0] op);
    if (op == OP_BEQ) return ALU_SUB;
    if (is_alu_op(op)) return op;
    return ALU_ADD;
  endfunction

  function automatic logic writes_reg(input logic [3:0] op);
    return is_alu_op(op) || (op == OP_LI);
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// mips_regfile: 16 x 16 general register file.
//   clk, rst       : clock, asynchronous active-high clear of every register
//   we, waddr,wdata: synchronous write port; writes to R0 are dropped
//   ra1/rd1, ra2/rd2: two asynchronous read ports; R0 always reads zero
module mips_regfile
  import mips_pkg::*;
#(
  parameter int width  = WORD_SIZE,
  parameter int addr_w = REG_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [addr_w-1:0] waddr,
  input  logic [width-1:0]  wdata,
  input  logic [addr_w-1:0] ra1,
  input  logic [addr_w-1:0] ra2,
  output logic [width-1:0]  rd1,
  output logic [width-1:0]  rd2
);

  localparam int depth = 1 << addr_w;

  logic [width-1:0] regs [0:depth-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < depth; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // R0 is forced on the read side as well, so it stays zero regardless of
  // what the storage cell holds.
  assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/mips_ctrl.sv
// mips_ctrl: multicycle control unit with integrated register file.
// Fetches the instruction at pc_counter, decodes it, drives the ALU operands,
// writes results back and steers the PC block with one-cycle strobes.
//   clk, rst            : clock, asynchronous active-high reset
//   en                  : step enable; when low every register holds
//   imem_req/ack/rdata  : instruction fetch handshake
//   pc_counter          : current PC (address of the fetch, owned by pc block)
//   data_1, data_2, sel : ALU operands and operation
//   alu_out, alu_zero_flag : ALU result and zero indication
//   pc_en, offset       : relative PC step strobe and signed step
//   load_pc, data_in    : absolute PC load strobe and target
//   halted              : high once a HALT instruction has been decoded
//
// state  | meaning
// FETCH  | imem_req high, wait for imem_ack, capture IR
// DECODE | read operands into data_1/data_2, pick sel; HALT exits here
// EXEC   | ALU sees operands; capture result, arm the PC strobe
// WB     | register write, PC strobe high for this (enabled) cycle
// HALT   | frozen until reset
module mips_ctrl
  import mips_pkg::*;
#(
  parameter int word_size   = WORD_SIZE,
  parameter int op_size     = OP_SIZE,
  parameter int offset_size = OFFSET_SIZE,
  parameter int mem_size    = MEM_SIZE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   imem_req,
  input  logic                   imem_ack,
  input  logic [word_size-1:0]   imem_rdata,
  input  logic [word_size-1:0]   pc_counter,
  output logic [word_size-1:0]   data_1,
  output logic [word_size-1:0]   data_2,
  output logic [op_size-1:0]     sel,
  input  logic [word_size-1:0]   alu_out,
  input  logic                   alu_zero_flag,
  output logic                   pc_en,
  output logic [offset_size-1:0] offset,
  output logic                   load_pc,
  output logic [word_size-1:0]   data_in,
  output logic                   halted
);

  state_t               state;
  logic [word_size-1:0] ir;
  logic [word_size-1:0] result;
  logic                 wb_we;

  logic [op_size-1:0]   op;
  logic [REG_ADDR-1:0]  rd;
  logic [REG_ADDR-1:0]  rs;
  logic [REG_ADDR-1:0]  rt;
  logic [REG_ADDR-1:0]  ra1;
  logic [REG_ADDR-1:0]  ra2;
  logic [word_size-1:0] rd1;
  logic [word_size-1:0] rd2;
  logic                 rf_we;

  // The PC block owns the fetch address; memory sees pc_counter directly,
  // so the controller itself never needs its value.
  logic unused_pc;
  assign unused_pc = ^pc_counter;

  assign op = ir[word_size-1 -: op_size];
  assign rd = ir[11:8];
  assign rs = ir[7:4];
  assign rt = ir[3:0];

  // BEQ compares rd against rs; everything else reads rs and rt.
  assign ra1 = (op == OP_BEQ) ? rd : rs;
  assign ra2 = (op == OP_BEQ) ? rs : rt;

  // Write happens on the edge that leaves WB, so a stalled WB writes once.
  assign rf_we = en && (state == S_WB) && wb_we;

  mips_regfile #(
    .width  (word_size),
    .addr_w (REG_ADDR)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (rf_we),
    .waddr (rd),
    .wdata (result),
    .ra1   (ra1),
    .ra2   (ra2),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_FETCH;
      ir       <= '0;
      result   <= '0;
      wb_we    <= 1'b0;
      imem_req <= 1'b0;
      data_1   <= '0;
      data_2   <= '0;
      sel      <= '0;
      pc_en    <= 1'b0;
      offset   <= '0;
      load_pc  <= 1'b0;
      data_in  <= '0;
      halted   <= 1'b0;
    end else if (en) begin
      unique case (state)
        S_FETCH: begin
          // req comes up one cycle into FETCH after reset; an ack is only
          // honoured while our request is actually visible to memory.
          if (imem_req && imem_ack) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            state    <= S_DECODE;
          end else begin
            imem_req <= 1'b1;
          end
        end

        S_DECODE: begin
          if (op == OP_HALT) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            data_1 <= rd1;
            data_2 <= rd2;
            sel    <= alu_sel_for(op);
            state  <= S_EXEC;
          end
        end

        S_EXEC: begin
          result <= (op == OP_LI) ? {{(word_size-8){1'b0}}, ir[7:0]} : alu_out;
          wb_we  <= writes_reg(op);
          if (op == OP_JMP) begin
            load_pc <= 1'b1;
            data_in <= {{(word_size-mem_size){1'b0}}, ir[mem_size-1:0]};
          end else begin
            pc_en <= 1'b1;
            // Branch offset is passed through raw; the PC block sign-extends.
            if ((op == OP_BEQ) && alu_zero_flag) begin
              offset <= ir[offset_size-1:0];
            end else begin
              offset <= offset_size'(1);
            end
          end
          state <= S_WB;
        end

        S_WB: begin
          pc_en    <= 1'b0;
          load_pc  <= 1'b0;
          wb_we    <= 1'b0;
          imem_req <= 1'b1;
          state    <= S_FETCH;
        end

        S_HALT: begin
        end

        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_ctrl.sv
// tb_mips_ctrl: the bench plays instruction memory, ALU and PC block around
// mips_ctrl. A small architectural model predicts, at every fetch handshake,
// the operands and PC strobe of that instruction and queues them; each WB
// strobe pops one entry and compares.
module tb_mips_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        imem_req;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] pc_counter;
  logic [15:0] data_1;
  logic [15:0] data_2;
  logic [3:0]  sel;
  logic [15:0] alu_out;
  logic        alu_zero_flag;
  logic        pc_en;
  logic [3:0]  offset;
  logic        load_pc;
  logic [15:0] data_in;
  logic        halted;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          chk_ops;
    logic [3:0]  sel;
    logic [15:0] d1;
    logic [15:0] d2;
    bit          is_jmp;
    logic [3:0]  off;
    logic [15:0] tgt;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] mem  [0:255];
  logic [15:0] mreg [0:15];
  bit          exp_halt;

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_f(input logic [3:0] s, input logic [15:0] a, input logic [15:0] b);
    case (s)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return a << b[3:0];
      4'h6: return a >> b[3:0];
      4'h7: return ($signed(a) < $signed(b)) ? 16'h0001 : 16'h0000;
      default: return 16'h0000;
    endcase
  endfunction

  assign alu_out       = alu_f(sel, data_1, data_2);
  assign alu_zero_flag = (alu_out == 16'h0000);

  mips_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .imem_req      (imem_req),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .pc_counter    (pc_counter),
    .data_1        (data_1),
    .data_2        (data_2),
    .sel           (sel),
    .alu_out       (alu_out),
    .alu_zero_flag (alu_zero_flag),
    .pc_en         (pc_en),
    .offset        (offset),
    .load_pc       (load_pc),
    .data_in       (data_in),
    .halted        (halted)
  );

  task automatic push_expect(input logic [15:0] ins);
    exp_t e;
    logic [3:0]  op, rd, rs, rt;
    logic [15:0] a, b;
    op = ins[15:12]; rd = ins[11:8]; rs = ins[7:4]; rt = ins[3:0];
    e.chk_ops = 0; e.sel = 4'h0; e.d1 = 16'h0; e.d2 = 16'h0;
    e.is_jmp = 0; e.off = 4'h1; e.tgt = 16'h0;
    if (op == 4'hF) begin
      exp_halt = 1;
      return;
    end
    if (!op[3]) begin
      a = mreg[rs]; b = mreg[rt];
      e.chk_ops = 1; e.sel = op; e.d1 = a; e.d2 = b;
      if (rd != 4'h0) mreg[rd] = alu_f(op, a, b);
    end else if (op == 4'h8) begin
      if (rd != 4'h0) mreg[rd] = {8'h00, ins[7:0]};
    end else if (op == 4'h9) begin
      a = mreg[rd]; b = mreg[rs];
      e.chk_ops = 1; e.sel = 4'h1; e.d1 = a; e.d2 = b;
      if (a == b) e.off = rt;
    end else if (op == 4'hA) begin
      e.is_jmp = 1; e.tgt = {8'h00, ins[7:0]};
    end
    sbq.push_back(e);
  endtask

  // Runs instructions from mem starting at pc_counter until n PC strobes
  // have been retired (and, with want_halt, until halted rises).
  task automatic run_prog(input int n, input int ack_delay, input bit noisy,
                          input bit en_rand, input bit want_halt);
    int   retired, wait_cnt;
    bit   ack_driven, strobe_prev, en_last, done;
    exp_t e;
    retired = 0; wait_cnt = 0; ack_driven = 0; strobe_prev = 0; done = 0;
    exp_halt = 0;
    for (int cyc = 0; cyc < 800 && !done; cyc++) begin
      @(negedge clk);
      en_last = en;
      if (pc_en || load_pc) begin
        if (strobe_prev && !en_last) begin
          // WB stalled by en=0; the strobe is expected to stay up
        end else if (strobe_prev) begin
          checks++; errors++;
          $display("FAIL double_strobe: pc_en=%0b load_pc=%0b high for two enabled cycles", pc_en, load_pc);
        end else begin
          checks++;
          if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_strobe: pc_en=%0b load_pc=%0b with nothing expected", pc_en, load_pc);
          end else begin
            e = sbq.pop_front();
            checks++;
            if ({pc_en, load_pc} !== (e.is_jmp ? 2'b01 : 2'b10)) begin
              errors++;
              $display("FAIL strobe_kind: pc_en,load_pc=%b expected %b", {pc_en, load_pc}, (e.is_jmp ? 2'b01 : 2'b10));
            end
            checks++;
            if (e.is_jmp) begin
              if (data_in !== e.tgt) begin
                errors++;
                $display("FAIL jump_target: data_in=%h expected %h", data_in, e.tgt);
              end
              pc_counter = e.tgt;
            end else begin
              if (offset !== e.off) begin
                errors++;
                $display("FAIL pc_offset: offset=%h expected %h (pc=%h)", offset, e.off, pc_counter);
              end
              pc_counter = pc_counter + {{12{e.off[3]}}, e.off};
            end
            if (e.chk_ops) begin
              checks++;
              if ({sel, data_1, data_2} !== {e.sel, e.d1, e.d2}) begin
                errors++;
                $display("FAIL operands: sel=%h d1=%h d2=%h expected sel=%h d1=%h d2=%h",
                         sel, data_1, data_2, e.sel, e.d1, e.d2);
              end
            end
            retired++;
          end
        end
      end
      strobe_prev = pc_en || load_pc;

      if (halted) begin
        checks++;
        if (!want_halt || !exp_halt || imem_req !== 1'b0) begin
          errors++;
          $display("FAIL halt_entry: halted=1 imem_req=%0b expected halt=%0b", imem_req, exp_halt);
        end
        done = 1;
      end

      if (ack_driven) begin
        checks++;
        if (imem_req !== !en_last) begin
          errors++;
          $display("FAIL req_drop: imem_req=%0b expected %0b after ack", imem_req, !en_last);
        end
        if (en_last) ack_driven = 0;
      end

      if (!done) done = (retired >= n) && !(pc_en || load_pc) && !want_halt;

      if (!ack_driven) begin
        if (imem_req && !done) begin
          if (wait_cnt >= ack_delay) begin
            imem_ack   = 1'b1;
            imem_rdata = mem[pc_counter[7:0]];
            push_expect(imem_rdata);
            ack_driven = 1;
            wait_cnt   = 0;
          end else begin
            imem_ack   = 1'b0;
            imem_rdata = 16'hA0FF;
            wait_cnt++;
          end
        end else begin
          imem_ack   = noisy && !done;
          imem_rdata = 16'hA0FF;
        end
      end
      en = en_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout: retired %0d of %0d instructions", retired, n);
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d expected strobes never seen", sbq.size());
      sbq.delete();
    end
    imem_ack = 1'b0;
    en = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; imem_ack = 1'b0; imem_rdata = 16'h0000; pc_counter = 16'h0000;
    for (int i = 0; i < 16; i++) mreg[i] = 16'h0000;
    repeat (2) @(negedge clk);
    checks++;
    if ({imem_req, pc_en, load_pc, halted} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_strobes: req,pc_en,load_pc,halted=%b expected 0000", {imem_req, pc_en, load_pc, halted});
    end
    checks++;
    if ({data_1, data_2, sel, offset, data_in} !== 56'h0) begin
      errors++;
      $display("FAIL reset_data: d1=%h d2=%h sel=%h off=%h din=%h expected all 0", data_1, data_2, sel, offset, data_in);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1) begin
      errors++;
      $display("FAIL reset_req_rise: imem_req=%0b expected 1", imem_req);
    end
  endtask

  task automatic test_alu();
    pc_counter = 16'h0000;
    mem[0] = 16'h8105; mem[1] = 16'h8203; mem[2] = 16'h0312;
    mem[3] = 16'h1431; mem[4] = 16'h2532; mem[5] = 16'h3612;
    mem[6] = 16'h0012; mem[7] = 16'h0701; mem[8] = 16'h4854;
    run_prog(9, 0, 0, 0, 0);
    checks++;
    if (mreg[3] !== 16'h0008) begin
      errors++;
      $display("FAIL model_add: R3=%h expected 0008", mreg[3]);
    end
  endtask

  task automatic test_branch();
    pc_counter = 16'h0020;
    mem[8'h20] = 16'h911E; mem[8'h1E] = 16'h912E; mem[8'h1F] = 16'h9330;
    run_prog(4, 0, 0, 0, 0);
    pc_counter = 16'h0030;
    mem[8'h30] = 16'h911F; mem[8'h2F] = 16'hC000;
    run_prog(2, 0, 0, 0, 0);
    checks++;
    if (pc_counter !== 16'h0030) begin
      errors++;
      $display("FAIL branch_back: pc=%h expected 0030", pc_counter);
    end
  endtask

  task automatic test_jump();
    pc_counter = 16'h0050;
    mem[8'h50] = 16'hA040; mem[8'h40] = 16'hB000;
    run_prog(2, 0, 0, 0, 0);
  endtask

  task automatic test_fetch_wait();
    pc_counter = 16'h0060;
    mem[8'h60] = 16'h8733; mem[8'h61] = 16'h0770;
    run_prog(2, 3, 1, 0, 0);
  endtask

  task automatic test_reset_mid();
    int k;
    pc_counter = 16'h0070;
    mem[8'h70] = 16'h0312;
    k = 0;
    while (imem_req !== 1'b1 && k < 20) begin
      @(negedge clk); k++;
    end
    imem_ack = 1'b1; imem_rdata = mem[8'h70];
    @(negedge clk);
    imem_ack = 1'b0; imem_rdata = 16'hA0FF;
    @(negedge clk);
    checks++;
    if ({sel, data_1, data_2} !== {4'h0, mreg[1], mreg[2]}) begin
      errors++;
      $display("FAIL exec_operands: sel=%h d1=%h d2=%h expected 0 %h %h", sel, data_1, data_2, mreg[1], mreg[2]);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({imem_req, pc_en, load_pc, halted, data_1} !== 20'h0) begin
      errors++;
      $display("FAIL mid_reset_outputs: req,pc_en,load_pc,halted=%b d1=%h expected 0",
               {imem_req, pc_en, load_pc, halted}, data_1);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) mreg[i] = 16'h0000;
    @(negedge clk);
    checks++;
    if ({imem_req, pc_en, load_pc} !== 3'b100) begin
      errors++;
      $display("FAIL post_reset: req,pc_en,load_pc=%b expected 100", {imem_req, pc_en, load_pc});
    end
    pc_counter = 16'h0074;
    mem[8'h74] = 16'h0431;
    run_prog(1, 0, 0, 0, 0);
  endtask

  task automatic test_en_toggle();
    pc_counter = 16'h00A0;
    mem[8'hA0] = 16'h8211; mem[8'hA1] = 16'h0522; mem[8'hA2] = 16'hA0B0;
    mem[8'hB0] = 16'h9553; mem[8'hB3] = 16'h9253;
    run_prog(5, 1, 1, 1, 0);
    checks++;
    if (pc_counter !== 16'h00B4) begin
      errors++;
      $display("FAIL en_toggle_pc: pc=%h expected 00B4", pc_counter);
    end
  endtask

  task automatic test_halt();
    pc_counter = 16'h00C0;
    mem[8'hC0] = 16'h8155; mem[8'hC1] = 16'hF000;
    run_prog(1, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      en = 1'($urandom_range(0, 1));
      imem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if ({halted, imem_req, pc_en, load_pc} !== 4'b1000) begin
        errors++;
        $display("FAIL halt_hold: halted,req,pc_en,load_pc=%b expected 1000", {halted, imem_req, pc_en, load_pc});
      end
    end
    imem_ack = 1'b0; en = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'hB000;
    test_reset();
    test_alu();
    test_branch();
    test_jump();
    test_fetch_wait();
    test_reset_mid();
    test_en_toggle();
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
